// File: rtl/jtframe_ddram_bram.sv
// jtframe_ddram_bram
// Burst responder for the MiSTer-style ddram_* Avalon-MM interface, backed by
// on-chip block RAM. Answers the read and write bursts of DDR initiators with
// a fixed, deterministic latency. An optional periodic busy pulse exercises
// the initiator's wait-request handling.
//
// Parameters
//   AW     : BRAM depth in 64-bit words is 2^AW
//   STALL  : busy-injection period in cycles, 0 disables injection
//
// Ports
//   clk              : single clock for the whole block
//   rst              : synchronous, active-high reset
//   ddram_busy       : wait request back to the initiator
//   ddram_burstcnt   : burst length in beats, 0 stands for 256
//   ddram_addr       : 64-bit word address (upper bits alias)
//   ddram_rd         : read request
//   ddram_dout       : registered read data, holds between beats
//   ddram_dout_ready : one pulse per delivered read beat
//   ddram_we         : write request and write-beat valid
//   ddram_din        : write data
//   ddram_be         : byte enables, bit i covers din[8i+7:8i]

module jtframe_ddram_bram #(
   parameter int AW    = 10,
   parameter int STALL = 0
)(
   input  logic        clk,
   input  logic        rst,
   output logic        ddram_busy,
   input  logic [7:0]  ddram_burstcnt,
   input  logic [28:0] ddram_addr,
   input  logic        ddram_rd,
   output logic [63:0] ddram_dout,
   output logic        ddram_dout_ready,
   input  logic        ddram_we,
   input  logic [63:0] ddram_din,
   input  logic [7:0]  ddram_be
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;

   localparam int SW = (STALL > 1) ? $clog2(STALL) : 1;

   logic [63:0]   mem [0:(1<<AW)-1];

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [8:0]    cnt_q, cnt_d;
   logic          prime_q, prime_d;
   logic          dready_q, dready_d;
   logic [63:0]   dout_q;
   logic [SW-1:0] scnt_q, scnt_d;

   logic          stall;
   logic          stallNext;
   logic          wrEn;
   logic          rdEn;
   logic [AW-1:0] wrAddr;
   logic [8:0]    burstLen;
   logic          unused_addr;

   // Address bits above the BRAM depth are simply ignored, so the memory
   // aliases across the whole ddram address space.
   assign unused_addr = ^ddram_addr[28:AW];

   // A burst count of zero encodes the maximum burst of 256 beats.
   assign burstLen = (ddram_burstcnt == 8'd0) ? 9'd256 : {1'b0, ddram_burstcnt};

   // Free-running stall counter. Besides the stall flag of the current cycle
   // we also need the flag of the following cycle, because a read beat is
   // registered one edge ahead and must not land on a stall cycle.
   always_comb begin
      scnt_d    = scnt_q;
      stall     = 1'b0;
      stallNext = 1'b0;
      if (STALL > 0) begin
         stall     = (scnt_q == SW'(STALL-1));
         scnt_d    = stall ? '0 : scnt_q + SW'(1);
         stallNext = (scnt_d == SW'(STALL-1));
      end
   end

   // While reading, busy is low only on data beats so the initiator sees its
   // data strobe and the wait request as complementary signals. Reset forces
   // busy high and masks any beat that was registered before the reset edge.
   assign ddram_busy       = rst | ((state_q == RD) ? ~dready_q : stall);
   assign ddram_dout_ready = dready_q & ~rst;
   assign ddram_dout       = dout_q;

   // Writes commit on the very edge where we & !busy is seen. The first beat
   // uses the address on the bus; later beats use the internal counter.
   assign wrEn   = ~rst & ddram_we & ~stall & ((state_q == IDLE) | (state_q == WR));
   assign wrAddr = (state_q == IDLE) ? ddram_addr[AW-1:0] : addr_q;

   // Burst sequencing. In IDLE a write wins over a simultaneous read; the
   // read stays pending on the bus and is taken once the write has finished.
   // In RD the first cycle only primes the pipeline, which gives the two
   // cycle latency from acceptance to the first data strobe.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      prime_d  = prime_q;
      dready_d = 1'b0;
      rdEn     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!stall) begin
               if (ddram_we) begin
                  addr_d = ddram_addr[AW-1:0] + AW'(1);
                  cnt_d  = burstLen - 9'd1;
                  if (burstLen != 9'd1) state_d = WR;
               end else if (ddram_rd) begin
                  addr_d  = ddram_addr[AW-1:0];
                  cnt_d   = burstLen;
                  prime_d = 1'b0;
                  state_d = RD;
               end
            end
         end
         WR: begin
            if (ddram_we && !stall) begin
               addr_d = addr_q + AW'(1);
               cnt_d  = cnt_q - 9'd1;
               if (cnt_q == 9'd1) state_d = IDLE;
            end
         end
         RD: begin
            if (!prime_q) begin
               prime_d = 1'b1;
            end else if (cnt_q == 9'd0) begin
               state_d = IDLE;
            end else if (!stallNext) begin
               rdEn     = 1'b1;
               dready_d = 1'b1;
               addr_d   = addr_q + AW'(1);
               cnt_d    = cnt_q - 9'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers and the registered read data port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         prime_q  <= 1'b0;
         dready_q <= 1'b0;
         dout_q   <= '0;
         scnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         prime_q  <= prime_d;
         dready_q <= dready_d;
         scnt_q   <= scnt_d;
         if (rdEn) dout_q <= mem[addr_q];
      end
   end

   // Byte-masked write port. The array has no reset so it maps onto block
   // RAM, and its contents survive a reset.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int i = 0; i < 8; i++) begin
            if (ddram_be[i]) mem[wrAddr][8*i +: 8] <= ddram_din[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_jtframe_ddram_bram.sv
// Testbench for jtframe_ddram_bram. Two instances share one stimulus bus:
// instance A is 1024 words deep without stalls, instance B is 16 words deep
// with a stall every 5th cycle. 'sel' picks which one sees rd/we.

module tb_jtframe_ddram_bram;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  burstcnt;
   logic [28:0] addr;
   logic        rd;
   logic        we;
   logic [63:0] din;
   logic [7:0]  be;
   logic        sel;

   logic        busyA, busyB, readyA, readyB;
   logic [63:0] doutA, doutB;
   logic        busy, ready;
   logic [63:0] dout;

   int assertions = 0;
   int failures   = 0;
   int cyc;

   // Reference memory, one bank per instance, with per-byte "written" flags
   // since the block RAM contents are undefined until written.
   logic [63:0] refMem   [2][1024];
   bit   [7:0]  refKnown [2][1024];
   logic [63:0] wq[$];

   always #5 clk = ~clk;

   // Cycle count since reset release; it is the phase of the stall pattern.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   assign busy  = sel ? busyB  : busyA;
   assign ready = sel ? readyB : readyA;
   assign dout  = sel ? doutB  : doutA;

   jtframe_ddram_bram #(.AW(10), .STALL(0)) dutA (
      .clk(clk), .rst(rst), .ddram_busy(busyA), .ddram_burstcnt(burstcnt),
      .ddram_addr(addr), .ddram_rd(rd & ~sel), .ddram_dout(doutA),
      .ddram_dout_ready(readyA), .ddram_we(we & ~sel), .ddram_din(din),
      .ddram_be(be)
   );

   jtframe_ddram_bram #(.AW(4), .STALL(5)) dutB (
      .clk(clk), .rst(rst), .ddram_busy(busyB), .ddram_burstcnt(burstcnt),
      .ddram_addr(addr), .ddram_rd(rd & sel), .ddram_dout(doutB),
      .ddram_dout_ready(readyB), .ddram_we(we & sel), .ddram_din(din),
      .ddram_be(be)
   );

   // True when the current cycle of the selected instance is a stall cycle.
   function automatic bit stallNow();
      int p;
      p = sel ? 5 : 0;
      return (p > 0) && ((cyc % p) == (p - 1));
   endfunction

   function automatic int wrapIdx(input int w);
      return sel ? (w & 15) : (w & 1023);
   endfunction

   task automatic modelWrite(input int w, input logic [63:0] d, input logic [7:0] b);
      int s;
      int i;
      s = sel ? 1 : 0;
      i = wrapIdx(w);
      for (int k = 0; k < 8; k++) begin
         if (b[k]) begin
            refMem[s][i][8*k +: 8] = d[8*k +: 8];
            refKnown[s][i][k] = 1'b1;
         end
      end
   endtask

   // Word address with random junk in the aliased upper bits.
   task automatic setAddr(input int w);
      logic [28:0] m;
      m = sel ? 29'd15 : 29'd1023;
      addr = (29'($urandom()) & ~m) | (29'(w) & m);
   endtask

   task automatic fillRand(input int n);
      wq.delete();
      repeat (n) wq.push_back({$urandom(), $urandom()});
   endtask

   // Drives one write burst from wq, honouring busy, optionally dropping we
   // for gapLen cycles before beat gapAt and optionally holding rd high.
   task automatic writeBurst(input int base, input int n, input logic [7:0] beVal,
                             input int gapAt, input int gapLen, input bit holdRd,
                             input bit chain);
      int beat    = 0;
      int guard   = 0;
      int gapLeft = gapLen;
      while (beat < n && guard < 4000) begin
         @(negedge clk);
         guard++;
         rd = holdRd;
         assertions++;
         if (busy !== stallNow()) begin
            failures++;
            $display("[TB] FAIL wr_busy cyc %0d: got %b expected %b", cyc, busy, stallNow());
         end
         if (beat == gapAt && gapLeft > 0) begin
            we = 1'b0;
            gapLeft--;
         end else begin
            we = 1'b1;
            if (beat == 0) setAddr(base);
            else           addr = 29'($urandom());
            burstcnt = 8'(n);
            din      = wq[beat];
            be       = beVal;
            if (!busy) begin
               modelWrite(base + beat, wq[beat], beVal);
               beat++;
            end
         end
      end
      assertions++;
      if (beat != n) begin
         failures++;
         $display("[TB] FAIL wr_timeout: got %0d beats expected %0d", beat, n);
      end
      if (!chain) begin
         @(negedge clk);
         we = 1'b0;
         rd = 1'b0;
      end
   endtask

   // Issues one read burst and checks the strobe against the ideal schedule:
   // first beat two edges after acceptance, then one beat on every non-stall
   // cycle. Returns early after abortAt beats when abortAt >= 0.
   task automatic readBurst(input int base, input int n, input int abortAt, input bit chain);
      int got   = 0;
      int k     = 0;
      int waitc = 0;
      bit acc   = 0;
      bit expRdy;
      int s;
      int i;
      logic [63:0] mask;
      s = sel ? 1 : 0;
      while (!acc && waitc < 20) begin
         @(negedge clk);
         waitc++;
         we = 1'b0;
         rd = 1'b1;
         setAddr(base);
         burstcnt = 8'(n);
         assertions++;
         if (busy !== stallNow() || ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_busy cyc %0d: got busy %b ready %b expected busy %b ready 0",
                     cyc, busy, ready, stallNow());
         end
         if (!busy) acc = 1;
      end
      if (!acc) begin
         assertions++;
         failures++;
         $display("[TB] FAIL rd_accept: got no acceptance expected one within 20 cycles");
         rd = 1'b0;
         return;
      end
      while (got < n && k < 2*n + 20) begin
         @(negedge clk);
         rd   = 1'b0;
         addr = 29'($urandom());
         expRdy = (k >= 2) && !stallNow();
         assertions++;
         if (ready !== expRdy) begin
            failures++;
            $display("[TB] FAIL rd_ready k %0d beat %0d: got %b expected %b", k, got, ready, expRdy);
         end
         assertions++;
         if (busy !== !ready) begin
            failures++;
            $display("[TB] FAIL rd_busy k %0d: got %b expected %b", k, busy, !ready);
         end
         if (ready === 1'b1) begin
            i = wrapIdx(base + got);
            mask = '0;
            for (int b = 0; b < 8; b++) if (refKnown[s][i][b]) mask[8*b +: 8] = 8'hFF;
            if (mask != 64'd0) begin
               assertions++;
               if ((dout & mask) !== (refMem[s][i] & mask)) begin
                  failures++;
                  $display("[TB] FAIL rd_data word %0d: got %h expected %h", i, dout & mask,
                           refMem[s][i] & mask);
               end
            end
            got++;
         end
         k++;
         if (got == abortAt) return;
      end
      assertions++;
      if (got != n) begin
         failures++;
         $display("[TB] FAIL rd_timeout: got %0d beats expected %0d", got, n);
      end
      if (!chain) begin
         @(negedge clk);
         assertions++;
         if (ready !== 1'b0 || busy !== stallNow()) begin
            failures++;
            $display("[TB] FAIL rd_end: got busy %b ready %b expected busy %b ready 0",
                     busy, ready, stallNow());
         end
      end
   endtask

   // Outputs while reset is held and immediately after release.
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      assertions++;
      if (busyA !== 1'b1 || busyB !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_busy: got %b/%b expected 1/1", busyA, busyB);
      end
      assertions++;
      if (readyA !== 1'b0 || readyB !== 1'b0 || doutA !== 64'd0 || doutB !== 64'd0) begin
         failures++;
         $display("[TB] FAIL reset_out: got ready %b/%b dout %h/%h expected 0", readyA, readyB,
                  doutA, doutB);
      end
      rst = 1'b0;
      @(negedge clk);
      assertions++;
      if (busyA !== 1'b0 || busyB !== ((cyc % 5) == 4)) begin
         failures++;
         $display("[TB] FAIL reset_release: got busy %b/%b expected 0/%b", busyA, busyB,
                  (cyc % 5) == 4);
      end
   endtask

   // 128-beat write of the beat index into the low two bytes over known data.
   task automatic test_write_read();
      fillRand(128);
      writeBurst(32'h40, 128, 8'hFF, -1, 0, 0, 0);
      wq.delete();
      for (int j = 0; j < 128; j++) wq.push_back(64'(j));
      writeBurst(32'h40, 128, 8'h03, -1, 0, 0, 0);
      readBurst(32'h40, 128, -1, 0);
   endtask

   task automatic test_byte_enables();
      wq.delete();
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      writeBurst(32'h10, 1, 8'hFF, -1, 0, 0, 0);
      wq.delete();
      wq.push_back(64'h0);
      writeBurst(32'h10, 1, 8'h0F, -1, 0, 0, 0);
      readBurst(32'h10, 1, -1, 0);
      assertions++;
      if (dout !== 64'hFFFF_FFFF_0000_0000) begin
         failures++;
         $display("[TB] FAIL byte_enable: got %h expected ffffffff00000000", dout);
      end
   endtask

   // Second read taken in the single IDLE cycle after the first one ends.
   task automatic test_back_to_back();
      fillRand(8);
      writeBurst(32'h300, 8, 8'hFF, -1, 0, 0, 0);
      readBurst(32'h300, 4, -1, 1);
      readBurst(32'h304, 4, -1, 0);
   endtask

   // 8-beat write with a 3-cycle we gap, framed by known neighbour words.
   task automatic test_write_gaps();
      fillRand(12);
      writeBurst(32'h200, 12, 8'hFF, -1, 0, 0, 0);
      fillRand(8);
      writeBurst(32'h202, 8, 8'hFF, 3, 3, 0, 0);
      readBurst(32'h200, 12, -1, 0);
   endtask

   task automatic test_reset_mid_burst();
      readBurst(32'h40, 128, 10, 0);
      rst = 1'b1;
      #1;
      assertions++;
      if (busyA !== 1'b1 || readyA !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_assert: got busy %b ready %b expected 1/0", busyA, readyA);
      end
      @(negedge clk);
      assertions++;
      if (busyA !== 1'b1 || readyA !== 1'b0 || doutA !== 64'd0) begin
         failures++;
         $display("[TB] FAIL midrst_hold: got busy %b ready %b dout %h expected 1/0/0",
                  busyA, readyA, doutA);
      end
      rst = 1'b0;
      @(negedge clk);
      assertions++;
      if (busyA !== 1'b0 || readyA !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_idle: got busy %b ready %b expected 0/0", busyA, readyA);
      end
      readBurst(32'h48, 8, -1, 0);
   endtask

   task automatic test_stall();
      fillRand(16);
      writeBurst(0, 16, 8'hFF, -1, 0, 0, 0);
      readBurst(0, 16, -1, 0);
   endtask

   // Write across the top of a 16-word memory while a read is held pending.
   task automatic test_wrap_collision();
      fillRand(4);
      writeBurst(14, 4, 8'hFF, -1, 0, 1, 1);
      readBurst(14, 4, -1, 0);
      readBurst(0, 2, -1, 0);
   endtask

   // Burst count 0 is a 256-beat burst, wrapping the small memory many times.
   task automatic test_long_burst();
      fillRand(256);
      writeBurst(5, 256, 8'hFF, -1, 0, 0, 0);
      readBurst(3, 256, -1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sel = 1'b0; rst = 1'b1; we = 1'b0; rd = 1'b0;
      burstcnt = '0; addr = '0; din = '0; be = '0;
      test_reset();
      test_write_read();
      test_byte_enables();
      test_back_to_back();
      test_write_gaps();
      test_reset_mid_burst();
      @(negedge clk);
      sel = 1'b1;
      test_stall();
      test_wrap_collision();
      test_long_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
